pwm_duty_ctrl: RTL and testbench
================================

Name: pwm_duty_ctrl

Overview:
Supervisory controller that sequences the 11-bit non-overlap PWM generator. It soft-starts the duty count and slew-limits later changes. Duty is updated only at PWM period boundaries. Over-current events are qualified against the PWM blanking window, and repeated faults produce a shutdown, cooldown, retry and lockout sequence. The block sits between the control loop (duty target, enable) and the PWM generator (duty, gating), and consumes the generator's period-sync and blanking outputs.

Parameters:
RAMP_STEP, 8, max duty increase per PWM period (counts)
DUTY_MAX, 1855, duty clip; keeps NONOVERLAP(64)+duty+blank(128) ≤ 2047
OVR_LIMIT, 3, consecutive over-current periods that trigger a fault
RETRY_PERIODS, 1024, PWM periods of cooldown; also the clean-run periods needed to clear the retry count
MAX_RETRIES, 4, faults allowed before lockout

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  asynchronous active-high reset
enable  in  1  run request from control logic
duty_target  in  11  requested duty count
PWM_synch  in  1  1-cycle pulse at PWM counter wrap
ovr_I_blank  in  1  blanking window from PWM generator; high = ignore ovr_I
ovr_I  in  1  over-current comparator, already synchronised
duty  out  11  duty count to PWM generator
pwm_en  out  1  output-stage gate; PWM1/PWM2 are forced low when 0
fault  out  1  high in FAULT, COOLDOWN or LOCKOUT
lockout  out  1  high in LOCKOUT only
state  out  3  current state encoding (debug)

Behaviour:
- Reset values (asynchronous, while rst=1): state=IDLE, duty=0, pwm_en=0, fault=0, lockout=0, all counters=0.
- Internal counters: ovr_cnt, period_cnt, retry_cnt.
- State encoding: IDLE=0, RAMP=1, RUN=2, FAULT=3, COOLDOWN=4, LOCKOUT=5. States 6 and 7 go to IDLE on the next clock.
- All outputs are registered.
- tgt = min(duty_target, DUTY_MAX).
- Over-current qualification:
  - ovr_seen is set on any cycle with ovr_I=1, ovr_I_blank=0 and pwm_en=1.
  - On each PWM_synch, ovr_seen is evaluated and then cleared. If ovr_I is qualified on the synch cycle itself, it counts toward the next period.
  - On synch: ovr_cnt = ovr_seen ? ovr_cnt+1 : 0, saturating at OVR_LIMIT.
- Duty update (RAMP/RUN only, on PWM_synch only):
  - If tgt < duty: duty = tgt (decreases take effect immediately).
  - Otherwise: duty = min(duty+RAMP_STEP, tgt), computed at 12-bit width, no overflow.
- IDLE: duty=0, pwm_en=0, retry_cnt=0. If enable=1 on a PWM_synch cycle → RAMP, pwm_en=1, duty stays 0 for that period.
- RAMP: duty update on each synch. When the updated duty equals tgt → RUN.
- RUN: duty update on each synch, with the same slew rule.
  - period_cnt counts synchs with ovr_seen=0 and resets on any ovr_seen.
  - When period_cnt reaches RETRY_PERIODS: retry_cnt=0, period_cnt=0.
- Fault entry (RAMP or RUN): on the synch where ovr_cnt becomes OVR_LIMIT → FAULT. Next cycle: duty=0, pwm_en=0, and that synch's duty update is suppressed.
- FAULT (one clock): retry_cnt += 1.
  - If the new retry_cnt == MAX_RETRIES → LOCKOUT.
  - Otherwise → COOLDOWN with period_cnt=0 and ovr_cnt=0.
- COOLDOWN: pwm_en=0. Counts synchs; at RETRY_PERIODS → RAMP from duty=0 with pwm_en=1.
- LOCKOUT: pwm_en=0, duty=0, lockout=1. Exits only on enable=0 → IDLE, which clears retry_cnt.
- enable=0 in RAMP, RUN, FAULT or COOLDOWN → IDLE on the next clock, asynchronous to synch. duty=0, pwm_en=0, ovr_cnt=0, retry_cnt=0.
- Simultaneous events on a synch cycle: enable=0 beats the fault transition; the fault transition beats the duty update.
- tgt=0 in RAMP: → RUN with duty=0 at the next synch.
- rst mid-operation: immediate return to reset values. A new start waits for a fresh synch with enable=1.

Test Plan:
- enable=1, duty_target=100, no ovr_I → duty steps 0, 8, 16 … 96, 100 on successive synchs; state=RUN on the synch where duty=100.
- In RUN at duty 500, set duty_target=2000 → slews by 8/period and settles at 1855. Then set duty_target=200 → duty=200 on the next synch.
- ovr_I pulses only while ovr_I_blank=1, for 10 periods → ovr_cnt stays 0, no fault.
- ovr_I with blank=0 in 3 consecutive periods → FAULT on the 3rd synch; next cycle pwm_en=0, duty=0, fault=1. After 1024 synchs the block returns to RAMP from 0.
- Persistent unblanked ovr_I → 4th fault enters LOCKOUT (lockout=1). It stays there with enable=1; enable=0 → IDLE with retry_cnt=0.
- rst=1 asserted mid-RAMP at duty 48 → all outputs 0 immediately. Also: enable=0 and the fault-triggering synch in the same cycle → IDLE, fault stays 0.

Source files
------------

// File: rtl/pwm_duty_ctrl.sv
// Supervisory sequencer for the non-overlap PWM generator: soft-start, slew limiting,
// blanking-qualified over-current detection and fault/cooldown/retry/lockout handling.
module pwm_duty_ctrl #(
    parameter int unsigned RAMP_STEP     = 8,
    parameter int unsigned DUTY_MAX      = 1855,
    parameter int unsigned OVR_LIMIT     = 3,
    parameter int unsigned RETRY_PERIODS = 1024,
    parameter int unsigned MAX_RETRIES   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [10:0] duty_target,
    input  logic        PWM_synch,
    input  logic        ovr_I_blank,
    input  logic        ovr_I,
    output logic [10:0] duty,
    output logic        pwm_en,
    output logic        fault,
    output logic        lockout,
    output logic [2:0]  state
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] RAMP     = 3'd1;
    localparam logic [2:0] RUN      = 3'd2;
    localparam logic [2:0] FAULT    = 3'd3;
    localparam logic [2:0] COOLDOWN = 3'd4;
    localparam logic [2:0] LOCKOUT  = 3'd5;

    localparam int unsigned OCW = $clog2(OVR_LIMIT + 1);
    localparam int unsigned PCW = $clog2(RETRY_PERIODS + 1);
    localparam int unsigned RCW = $clog2(MAX_RETRIES + 1);

    logic [2:0]     state_q, state_d;
    logic [10:0]    duty_q, duty_d;
    logic           pwm_en_q, pwm_en_d;
    logic           fault_q, fault_d;
    logic           lockout_q, lockout_d;
    logic           ovr_seen_q, ovr_seen_d;
    logic [OCW-1:0] ovr_cnt_q, ovr_cnt_d;
    logic [PCW-1:0] period_cnt_q, period_cnt_d;
    logic [RCW-1:0] retry_cnt_q, retry_cnt_d;

    logic [10:0]    tgt;
    logic [11:0]    duty_up;
    logic [10:0]    duty_slew;
    logic           ovr_qual;
    logic [OCW-1:0] ovr_cnt_upd;
    logic [RCW-1:0] retry_inc;

    assign tgt       = (duty_target > 11'(DUTY_MAX)) ? 11'(DUTY_MAX) : duty_target;
    assign duty_up   = {1'b0, duty_q} + 12'(RAMP_STEP);
    assign ovr_qual  = ovr_I & ~ovr_I_blank & pwm_en_q;
    assign retry_inc = retry_cnt_q + 1'b1;

    always_comb begin
        if (tgt < duty_q) begin
            duty_slew = tgt;
        end else if (duty_up > {1'b0, tgt}) begin
            duty_slew = tgt;
        end else begin
            duty_slew = duty_up[10:0];
        end
    end

    always_comb begin
        if (!ovr_seen_q) begin
            ovr_cnt_upd = '0;
        end else if (ovr_cnt_q >= OCW'(OVR_LIMIT)) begin
            ovr_cnt_upd = ovr_cnt_q;
        end else begin
            ovr_cnt_upd = ovr_cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        duty_d       = duty_q;
        ovr_seen_d   = ovr_seen_q;
        ovr_cnt_d    = ovr_cnt_q;
        period_cnt_d = period_cnt_q;
        retry_cnt_d  = retry_cnt_q;

        case (state_q)
            IDLE: begin
                duty_d       = '0;
                ovr_seen_d   = 1'b0;
                ovr_cnt_d    = '0;
                period_cnt_d = '0;
                retry_cnt_d  = '0;
                if (enable && PWM_synch) begin
                    state_d = RAMP;
                end
            end
            RAMP, RUN: begin
                // A hit on the synch cycle itself belongs to the period that is starting.
                ovr_seen_d = ovr_qual | (ovr_seen_q & ~PWM_synch);
                if (PWM_synch) begin
                    ovr_cnt_d = ovr_cnt_upd;
                    if (ovr_cnt_upd == OCW'(OVR_LIMIT)) begin
                        state_d = FAULT;
                        duty_d  = '0;
                    end else begin
                        duty_d = duty_slew;
                        if (state_q == RAMP) begin
                            if (duty_slew == tgt) begin
                                state_d = RUN;
                            end
                        end else if (ovr_seen_q) begin
                            period_cnt_d = '0;
                        end else if (period_cnt_q == PCW'(RETRY_PERIODS - 1)) begin
                            period_cnt_d = '0;
                            retry_cnt_d  = '0;
                        end else begin
                            period_cnt_d = period_cnt_q + 1'b1;
                        end
                    end
                end
            end
            FAULT: begin
                duty_d       = '0;
                ovr_seen_d   = 1'b0;
                ovr_cnt_d    = '0;
                period_cnt_d = '0;
                retry_cnt_d  = retry_inc;
                state_d      = (retry_inc == RCW'(MAX_RETRIES)) ? LOCKOUT : COOLDOWN;
            end
            COOLDOWN: begin
                duty_d     = '0;
                ovr_seen_d = 1'b0;
                ovr_cnt_d  = '0;
                if (PWM_synch) begin
                    if (period_cnt_q == PCW'(RETRY_PERIODS - 1)) begin
                        period_cnt_d = '0;
                        state_d      = RAMP;
                    end else begin
                        period_cnt_d = period_cnt_q + 1'b1;
                    end
                end
            end
            LOCKOUT: begin
                duty_d     = '0;
                ovr_seen_d = 1'b0;
                ovr_cnt_d  = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Dropping enable overrides every synch-time event, including a fault trip.
        if (state_q != IDLE && !enable) begin
            state_d      = IDLE;
            duty_d       = '0;
            ovr_seen_d   = 1'b0;
            ovr_cnt_d    = '0;
            period_cnt_d = '0;
            retry_cnt_d  = '0;
        end
    end

    always_comb begin
        pwm_en_d  = (state_d == RAMP) || (state_d == RUN);
        fault_d   = (state_d == FAULT) || (state_d == COOLDOWN) || (state_d == LOCKOUT);
        lockout_d = (state_d == LOCKOUT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            duty_q       <= '0;
            pwm_en_q     <= 1'b0;
            fault_q      <= 1'b0;
            lockout_q    <= 1'b0;
            ovr_seen_q   <= 1'b0;
            ovr_cnt_q    <= '0;
            period_cnt_q <= '0;
            retry_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            duty_q       <= duty_d;
            pwm_en_q     <= pwm_en_d;
            fault_q      <= fault_d;
            lockout_q    <= lockout_d;
            ovr_seen_q   <= ovr_seen_d;
            ovr_cnt_q    <= ovr_cnt_d;
            period_cnt_q <= period_cnt_d;
            retry_cnt_q  <= retry_cnt_d;
        end
    end

    assign duty    = duty_q;
    assign pwm_en  = pwm_en_q;
    assign fault   = fault_q;
    assign lockout = lockout_q;
    assign state   = state_q;

endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// Bench for pwm_duty_ctrl: directed sequences pinned by literals, then random stimulus,
// with a per-cycle comparison against an integer-level behavioural model.
module tb_pwm_duty_ctrl;

    localparam int DMAX  = 1855;
    localparam int STEP  = 8;
    localparam int OLIM  = 3;
    localparam int RPER  = 1024;
    localparam int MRETR = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic [10:0] duty_target = '0;
    logic        PWM_synch = 1'b0;
    logic        ovr_I_blank = 1'b0;
    logic        ovr_I = 1'b0;
    logic [10:0] duty;
    logic        pwm_en;
    logic        fault;
    logic        lockout;
    logic [2:0]  state;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;

    // Model state: 0 idle, 1 ramp, 2 run, 3 fault, 4 cooldown, 5 lockout.
    int m_state, m_duty, m_retries, m_bad, m_clean, m_cool;
    bit m_seen;

    pwm_duty_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .duty_target (duty_target),
        .PWM_synch   (PWM_synch),
        .ovr_I_blank (ovr_I_blank),
        .ovr_I       (ovr_I),
        .duty        (duty),
        .pwm_en      (pwm_en),
        .fault       (fault),
        .lockout     (lockout),
        .state       (state)
    );

    always #5 clk = ~clk;

    task automatic model_idle();
        m_state = 0; m_duty = 0; m_retries = 0; m_bad = 0; m_clean = 0; m_cool = 0; m_seen = 0;
    endtask

    task automatic model_step();
        int tgt;
        bit qual;
        tgt  = (int'(duty_target) > DMAX) ? DMAX : int'(duty_target);
        qual = (m_state == 1 || m_state == 2) && ovr_I && !ovr_I_blank;
        if (m_state != 0 && !enable) begin
            model_idle();
            return;
        end
        case (m_state)
            0: if (enable && PWM_synch) begin m_state = 1; m_duty = 0; end
            1, 2: begin
                if (PWM_synch) begin
                    m_bad = m_seen ? ((m_bad + 1 > OLIM) ? OLIM : m_bad + 1) : 0;
                    if (m_bad == OLIM) begin
                        m_state = 3;
                        m_duty  = 0;
                    end else begin
                        if (tgt < m_duty) m_duty = tgt;
                        else m_duty = (m_duty + STEP > tgt) ? tgt : m_duty + STEP;
                        if (m_state == 1) begin
                            if (m_duty == tgt) m_state = 2;
                        end else begin
                            m_clean = m_seen ? 0 : m_clean + 1;
                            if (m_clean == RPER) begin m_clean = 0; m_retries = 0; end
                        end
                    end
                    m_seen = qual;
                end else begin
                    m_seen = m_seen || qual;
                end
            end
            3: begin
                m_retries++;
                m_bad = 0; m_seen = 0; m_clean = 0; m_cool = 0;
                m_state = (m_retries == MRETR) ? 5 : 4;
            end
            4: if (PWM_synch) begin
                m_cool++;
                if (m_cool == RPER) begin m_state = 1; m_cool = 0; m_clean = 0; end
            end
            default: ;
        endcase
    endtask

    always @(negedge clk) begin
        if (chk_on && !rst) begin
            n_tests++;
            if (int'(duty) != m_duty || pwm_en != (m_state == 1 || m_state == 2) ||
                fault != (m_state >= 3) || lockout != (m_state == 5) ||
                int'(state) != m_state) begin
                n_fail++;
                $display("FAIL model_cmp t=%0t: got duty=%0d en=%0b flt=%0b lck=%0b st=%0d, expected duty=%0d st=%0d",
                         $time, duty, pwm_en, fault, lockout, state, m_duty, m_state);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    // One 4-cycle PWM period: two blanked cycles, one unblanked, then the synch cycle.
    task automatic period(input bit ov_unblk, input bit ov_blk, input bit en_sync);
        for (int i = 0; i < 4; i++) begin
            PWM_synch   = (i == 3);
            ovr_I_blank = (i < 2);
            ovr_I       = (i < 2) ? ov_blk : ((i == 2) ? ov_unblk : 1'b0);
            if (i == 3 && !en_sync) enable = 1'b0;
            tick();
        end
        PWM_synch = 1'b0;
        ovr_I     = 1'b0;
    endtask

    initial begin
        int np;
        model_idle();
        #1 rst = 1'b1;
        @(negedge clk);
        check("reset_duty", int'(duty), 0);
        check("reset_pwm_en", int'(pwm_en), 0);
        check("reset_state", int'(state), 0);
        check("reset_fault", int'(fault), 0);
        #2 rst = 1'b0;
        chk_on = 1'b1;
        @(negedge clk);

        // Soft start to 100.
        enable = 1'b1;
        duty_target = 11'd100;
        period(0, 0, 1);
        check("ramp_entry_state", int'(state), 1);
        check("ramp_entry_duty", int'(duty), 0);
        for (int k = 1; k <= 13; k++) begin
            period(0, 0, 1);
            check("ramp_step_duty", int'(duty), (8 * k > 100) ? 100 : 8 * k);
            check("ramp_step_state", int'(state), (k == 13) ? 2 : 1);
        end

        // Slew up to 500, then past the clip, then an immediate decrease.
        duty_target = 11'd500;
        repeat (55) period(0, 0, 1);
        check("run_500", int'(duty), 500);
        duty_target = 11'd2000;
        period(0, 0, 1);
        check("slew_first", int'(duty), 508);
        repeat (175) period(0, 0, 1);
        check("clip_1855", int'(duty), 1855);
        duty_target = 11'd200;
        period(0, 0, 1);
        check("drop_200", int'(duty), 200);

        // Over-current only inside blanking never counts.
        repeat (10) period(0, 1, 1);
        check("blanked_fault", int'(fault), 0);
        check("blanked_state", int'(state), 2);

        // Three qualified periods trip a fault, then cooldown and retry.
        repeat (3) period(1, 0, 1);
        check("fault_state", int'(state), 3);
        check("fault_pwm_en", int'(pwm_en), 0);
        check("fault_duty", int'(duty), 0);
        check("fault_flag", int'(fault), 1);
        repeat (1023) period(0, 0, 1);
        check("cooldown_state", int'(state), 4);
        period(0, 0, 1);
        check("retry_state", int'(state), 1);
        check("retry_duty", int'(duty), 0);
        check("retry_pwm_en", int'(pwm_en), 1);

        // Persistent over-current: three more faults reach lockout.
        np = 0;
        while (!lockout && np < 3000) begin
            period(1, 0, 1);
            np++;
        end
        check("lockout_periods", np, 2058);
        check("lockout_flag", int'(lockout), 1);
        repeat (5) period(1, 0, 1);
        check("lockout_hold", int'(state), 5);
        enable = 1'b0;
        tick();
        check("lockout_exit_state", int'(state), 0);
        check("lockout_exit_fault", int'(fault), 0);

        // Retry count was cleared: the next fault goes to cooldown, not lockout.
        enable = 1'b1;
        period(0, 0, 1);
        repeat (3) period(1, 0, 1);
        check("refault_state", int'(state), 3);
        tick();
        check("refault_cooldown", int'(state), 4);
        enable = 1'b0;
        tick();

        // Zero target in RAMP finishes at the first synch.
        duty_target = 11'd0;
        enable = 1'b1;
        period(0, 0, 1);
        period(0, 0, 1);
        check("tgt0_state", int'(state), 2);
        check("tgt0_duty", int'(duty), 0);
        enable = 1'b0;
        tick();

        // Asynchronous reset mid-ramp at duty 48.
        duty_target = 11'd300;
        enable = 1'b1;
        period(0, 0, 1);
        repeat (6) period(0, 0, 1);
        check("pre_rst_duty", int'(duty), 48);
        #2 rst = 1'b1;
        #1;
        check("async_rst_duty", int'(duty), 0);
        check("async_rst_pwm_en", int'(pwm_en), 0);
        check("async_rst_state", int'(state), 0);
        model_idle();
        @(negedge clk);
        #2 rst = 1'b0;
        tick();
        check("post_rst_idle", int'(state), 0);
        period(0, 0, 1);
        check("post_rst_ramp", int'(state), 1);

        // enable drop on the fault-triggering synch wins.
        repeat (2) period(1, 0, 1);
        period(1, 0, 0);
        check("simul_state", int'(state), 0);
        check("simul_fault", int'(fault), 0);

        // Random stimulus against the model.
        enable = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            PWM_synch   = ($urandom_range(0, 7) == 0);
            ovr_I_blank = 1'($urandom_range(0, 1));
            ovr_I       = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 49) == 0) duty_target = 11'($urandom_range(0, 2047));
            enable = ($urandom_range(0, 299) != 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
